// File: rtl/hid_inject_pkg.sv
// rtl/hid_inject_pkg.sv - shared encodings for the HID injection scheduler
// Purpose: source encoding, per-source report lengths and FSM state encoding
//          used by hid_inject_scheduler.
package hid_inject_pkg;

  // Source select; also the value driven on inj_src for the whole packet.
  typedef enum logic {
    SRC_KBD   = 1'b0,
    SRC_MOUSE = 1'b1
  } src_e;

  // Report lengths in bytes.
  localparam logic [3:0] KBD_LEN   = 4'd8;
  localparam logic [3:0] MOUSE_LEN = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hid_holdoff_timer.sv
// rtl/hid_holdoff_timer.sv - per-source holdoff down-counter
// Purpose: after load_i the counter holds MIN_GAP_CYCLES and then counts down
//          by one per cycle to zero; zero_o flags that the source may be granted.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset (counter cleared)
//   load_i  load MIN_GAP_CYCLES (takes priority over counting)
//   zero_o  counter is zero
module hid_holdoff_timer #(
  parameter int MIN_GAP_CYCLES = 60000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic zero_o
);

  // A gap of 0 or 1 still needs a one-bit counter.
  localparam int W = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES + 1) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(MIN_GAP_CYCLES);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hid_inject_scheduler.sv
// rtl/hid_inject_scheduler.sv - round-robin keyboard/mouse HID report injector
// Purpose: arbitrates keyboard and mouse injection requests onto one byte
//          port, serializes the granted report LSB byte first with a
//          ready/valid handshake, acks the requester and rate-limits each
//          source with a holdoff timer.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   enable                       allow new grants
//   inject_kbd_report/valid/ack  keyboard request (64-bit report), ack pulse
//   inject_mouse_report/valid/ack mouse request (40-bit report), ack pulse
//   inj_data/valid/ready         byte stream towards the endpoint mux
//   inj_first/inj_last/inj_src   byte position flags and packet source
//   busy                         FSM not idle
//   kbd_sent_count/mouse_sent_count saturating completed-packet counters
module hid_inject_scheduler
  import hid_inject_pkg::*;
#(
  parameter int MIN_GAP_CYCLES = 60000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [63:0]      inject_kbd_report,
  input  logic             inject_kbd_valid,
  output logic             inject_kbd_ack,
  input  logic [39:0]      inject_mouse_report,
  input  logic             inject_mouse_valid,
  output logic             inject_mouse_ack,
  output logic [7:0]       inj_data,
  output logic             inj_valid,
  input  logic             inj_ready,
  output logic             inj_first,
  output logic             inj_last,
  output logic             inj_src,
  output logic             busy,
  output logic [CNT_W-1:0] kbd_sent_count,
  output logic [CNT_W-1:0] mouse_sent_count
);

  state_e           state_q;
  logic [63:0]      shift_q;
  logic [3:0]       idx_q;
  logic [3:0]       len_q;
  src_e             src_q;
  src_e             last_grant_q;
  logic             valid_q;
  logic             first_q;
  logic             last_q;
  logic             kbd_ack_q;
  logic             mouse_ack_q;
  logic [CNT_W-1:0] kbd_cnt_q;
  logic [CNT_W-1:0] kbd_cnt_d;
  logic [CNT_W-1:0] mouse_cnt_q;
  logic [CNT_W-1:0] mouse_cnt_d;

  logic kbd_zero;
  logic mouse_zero;
  logic kbd_elig;
  logic mouse_elig;
  logic grant;
  logic grant_mouse;
  logic handshake;
  logic kbd_load;
  logic mouse_load;

  assign kbd_elig   = enable & inject_kbd_valid & kbd_zero;
  assign mouse_elig = enable & inject_mouse_valid & mouse_zero;
  assign grant      = kbd_elig | mouse_elig;
  // On a tie the source that was not granted last time wins.
  assign grant_mouse = mouse_elig & (~kbd_elig | (last_grant_q == SRC_KBD));
  assign handshake   = valid_q & inj_ready;

  // The DONE cycle both restarts the holdoff and counts the packet.
  assign kbd_load   = (state_q == ST_DONE) & (src_q == SRC_KBD);
  assign mouse_load = (state_q == ST_DONE) & (src_q == SRC_MOUSE);

  hid_holdoff_timer #(.MIN_GAP_CYCLES(MIN_GAP_CYCLES)) u_kbd_holdoff (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (kbd_load),
    .zero_o (kbd_zero)
  );

  hid_holdoff_timer #(.MIN_GAP_CYCLES(MIN_GAP_CYCLES)) u_mouse_holdoff (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (mouse_load),
    .zero_o (mouse_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      src_q        <= SRC_KBD;
      last_grant_q <= SRC_MOUSE;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      kbd_ack_q    <= 1'b0;
      mouse_ack_q  <= 1'b0;
    end else begin
      kbd_ack_q   <= 1'b0;
      mouse_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            if (grant_mouse) begin
              shift_q      <= {24'd0, inject_mouse_report};
              len_q        <= MOUSE_LEN;
              src_q        <= SRC_MOUSE;
              last_grant_q <= SRC_MOUSE;
            end else begin
              shift_q      <= inject_kbd_report;
              len_q        <= KBD_LEN;
              src_q        <= SRC_KBD;
              last_grant_q <= SRC_KBD;
            end
            idx_q   <= '0;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (handshake) begin
            shift_q <= {8'd0, shift_q[63:8]};
            idx_q   <= idx_q + 4'd1;
            first_q <= 1'b0;
            // Next byte index is idx+1; it is the last one when idx+1 == len-1.
            last_q  <= ((idx_q + 4'd2) == len_q);
            if (last_q) begin
              valid_q     <= 1'b0;
              kbd_ack_q   <= (src_q == SRC_KBD);
              mouse_ack_q <= (src_q == SRC_MOUSE);
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    kbd_cnt_d = kbd_cnt_q;
    if (kbd_load && (kbd_cnt_q != '1)) begin
      kbd_cnt_d = kbd_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    mouse_cnt_d = mouse_cnt_q;
    if (mouse_load && (mouse_cnt_q != '1)) begin
      mouse_cnt_d = mouse_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kbd_cnt_q   <= '0;
      mouse_cnt_q <= '0;
    end else begin
      kbd_cnt_q   <= kbd_cnt_d;
      mouse_cnt_q <= mouse_cnt_d;
    end
  end

  assign inj_data         = shift_q[7:0];
  assign inj_valid        = valid_q;
  assign inj_first        = first_q;
  assign inj_last         = last_q;
  assign inj_src          = src_q;
  assign busy             = (state_q != ST_IDLE);
  assign inject_kbd_ack   = kbd_ack_q;
  assign inject_mouse_ack = mouse_ack_q;
  assign kbd_sent_count   = kbd_cnt_q;
  assign mouse_sent_count = mouse_cnt_q;

endmodule

// File: tb/tb_hid_inject_scheduler.sv
// tb/tb_hid_inject_scheduler.sv - self-checking bench for hid_inject_scheduler
module tb_hid_inject_scheduler;

  localparam int GAP   = 100;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [63:0]      kbd_rep;
  logic             kbd_v;
  logic             kbd_ack;
  logic [39:0]      m_rep;
  logic             m_v;
  logic             m_ack;
  logic [7:0]       inj_data;
  logic             inj_valid;
  logic             inj_ready;
  logic             inj_first;
  logic             inj_last;
  logic             inj_src;
  logic             busy;
  logic [CNT_W-1:0] kcnt;
  logic [CNT_W-1:0] mcnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hid_inject_scheduler #(.MIN_GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .inject_kbd_report   (kbd_rep),
    .inject_kbd_valid    (kbd_v),
    .inject_kbd_ack      (kbd_ack),
    .inject_mouse_report (m_rep),
    .inject_mouse_valid  (m_v),
    .inject_mouse_ack    (m_ack),
    .inj_data            (inj_data),
    .inj_valid           (inj_valid),
    .inj_ready           (inj_ready),
    .inj_first           (inj_first),
    .inj_last            (inj_last),
    .inj_src             (inj_src),
    .busy                (busy),
    .kbd_sent_count      (kcnt),
    .mouse_sent_count    (mcnt)
  );

  typedef struct { bit src; logic [63:0] data; int start; int fin; } pkt_t;
  typedef struct { bit src; int cyc; } ack_t;
  typedef struct { bit k; bit m; logic [63:0] rk; logic [39:0] rm; int rdy; bit first; } vec_t;

  pkt_t        pkt_q[$];
  ack_t        ack_q[$];
  int          cur_n = 0;
  logic [63:0] cur_data;
  bit          cur_src;
  bit          in_pkt = 0;
  int          cur_start;
  int          valid_cycles = 0;
  bit          stall_q = 0;
  logic [10:0] st_snap;
  int          mlen;
  int          ready_pct = 100;
  // Reference model state: completed packet counts and last granted source.
  int          mk = 0;
  int          mm = 0;
  bit          lg_m = 1'b1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired waiting for DUT", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Random sink backpressure, changed just after each active edge.
  initial forever begin
    @(posedge clk);
    #1;
    inj_ready = ($urandom_range(99) < ready_pct);
  end

  // Stream monitor: rebuilds packets from handshakes and checks flags/stability.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      cur_n   = 0;
      in_pkt  = 0;
      stall_q = 0;
    end else begin
      if (inj_valid) valid_cycles++;
      if (stall_q)
        chk("stall_hold", {inj_valid, inj_data, inj_first, inj_last, inj_src}, {1'b1, st_snap});
      if (inj_valid && !in_pkt) begin
        in_pkt    = 1;
        cur_start = cyc;
        cur_src   = inj_src;
        cur_data  = '0;
        cur_n     = 0;
      end
      if (inj_valid && inj_ready) begin
        mlen = inj_src ? 5 : 8;
        chk("first_flag", inj_first, (cur_n == 0));
        chk("last_flag", inj_last, (cur_n == mlen - 1));
        chk("src_const", inj_src, cur_src);
        cur_data = cur_data | (64'(inj_data) << (8 * cur_n));
        cur_n++;
        if (cur_n == mlen) begin
          pkt_q.push_back('{cur_src, cur_data, cur_start, cyc});
          in_pkt = 0;
          cur_n  = 0;
        end
      end
      stall_q = inj_valid && !inj_ready;
      st_snap = {inj_data, inj_first, inj_last, inj_src};
      if (kbd_ack) ack_q.push_back('{1'b0, cyc});
      if (m_ack)   ack_q.push_back('{1'b1, cyc});
    end
  end

  task automatic req(input bit k, input bit m, input logic [63:0] rk, input logic [39:0] rm);
    if (k) begin kbd_v = 1'b1; kbd_rep = rk; end
    if (m) begin m_v = 1'b1; m_rep = rm; end
  endtask

  // Waits for the next packet and its ack; the requester then drops valid.
  task automatic expect_pkt(input bit src, input logic [63:0] want, input int want_start,
                            output int start, output int ackc);
    pkt_t p;
    ack_t a;
    int   t;
    start = -1;
    ackc  = -1;
    t = 0;
    while (pkt_q.size() == 0 && t < 3000) begin step(); t++; end
    if (pkt_q.size() == 0) begin fail("pkt_timeout"); return; end
    p = pkt_q.pop_front();
    chk("pkt_src", p.src, src);
    chk("pkt_data", p.data, want);
    if (want_start >= 0) chk("pkt_latency", p.start, want_start);
    start = p.start;
    t = 0;
    while (ack_q.size() == 0 && t < 10) begin step(); t++; end
    if (ack_q.size() == 0) begin fail("ack_timeout"); return; end
    a = ack_q.pop_front();
    chk("ack_src", a.src, src);
    chk("ack_time", a.cyc, p.fin + 1);
    ackc = a.cyc;
    if (src) begin m_v = 1'b0; mm++; end
    else begin kbd_v = 1'b0; mk++; end
    lg_m = src;
    chk("kbd_count", kcnt, mk);
    chk("mouse_count", mcnt, mm);
  endtask

  // Requests now (cycle n); first packet starts at n+1, a tied loser two cycles after the ack.
  task automatic run_case(input bit k, input bit m, input logic [63:0] rk,
                          input logic [39:0] rm, input bit first);
    int  n;
    int  s;
    int  a;
    int  a2;
    bit  w;
    n = cyc;
    req(k, m, rk, rm);
    w = (k && m) ? first : m;
    expect_pkt(w, w ? {24'd0, rm} : rk, n + 1, s, a);
    if (k && m) expect_pkt(~w, (~w) ? {24'd0, rm} : rk, a + 2, s, a2);
    idle(3);
    chk("no_extra_pkt", pkt_q.size(), 0);
    chk("no_extra_ack", ack_q.size(), 0);
  endtask

  vec_t        tbl[5];
  int          n;
  int          s;
  int          a;
  int          s2;
  int          a2;
  int          s3;
  int          a3;
  int          vc;
  int          t;
  int          kind;
  logic [63:0] rk;
  logic [39:0] rm;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 64'h0807060504030201, 40'h0504030201, 100, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 64'hdeadbeefcafef00d, 40'h0,          100, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 64'h1122334455667788, 40'h99aabbccdd, 100, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 64'h0,                40'h0102030405, 50,  1'b1};
    tbl[4] = '{1'b1, 1'b0, 64'h0f1e2d3c4b5a6978, 40'h0,          35,  1'b0};

    rst = 1'b1; enable = 1'b1; kbd_v = 1'b0; m_v = 1'b0;
    kbd_rep = '0; m_rep = '0; inj_ready = 1'b1;
    idle(3);
    chk("rst_stream", {inj_valid, inj_first, inj_last, inj_src, busy, kbd_ack, m_ack}, 7'd0);
    chk("rst_data", inj_data, 8'd0);
    chk("rst_counts", {kcnt, mcnt}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      ready_pct = tbl[i].rdy;
      run_case(tbl[i].k, tbl[i].m, tbl[i].rk, tbl[i].rm, tbl[i].first);
      idle(GAP + 10);
    end

    // Holdoff: keyboard re-requests at once, mouse slips in, keyboard waits out the gap.
    ready_pct = 100;
    n = cyc;
    req(1, 0, 64'ha1a2a3a4a5a6a7a8, 40'h0);
    expect_pkt(0, 64'ha1a2a3a4a5a6a7a8, n + 1, s, a);
    req(1, 1, 64'h5152535455565758, 40'h1234567890);
    expect_pkt(1, 64'h0000001234567890, a + 2, s2, a2);
    expect_pkt(0, 64'h5152535455565758, -1, s3, a3);
    chk("holdoff_min", (s3 >= a + GAP + 1), 1'b1);
    chk("holdoff_max", (s3 <= a + GAP + 2), 1'b1);
    idle(GAP + 10);

    // Enable gating.
    enable = 1'b0;
    vc = valid_cycles;
    req(1, 0, 64'h7766554433221100, 40'h0);
    idle(50);
    chk("en_gate_valid", valid_cycles, vc);
    chk("en_gate_busy", busy, 1'b0);
    n = cyc;
    enable = 1'b1;
    expect_pkt(0, 64'h7766554433221100, n + 1, s, a);
    idle(GAP + 10);
    n = cyc;
    req(1, 0, 64'hfedcba9876543210, 40'h0);
    t = 0;
    while (cur_n < 3 && t < 100) begin step(); t++; end
    if (cur_n < 3) fail("en_byte3_wait");
    enable = 1'b0;
    expect_pkt(0, 64'hfedcba9876543210, n + 1, s, a);
    vc = valid_cycles;
    req(0, 1, 64'h0, 40'h3344556677);
    idle(20);
    chk("en_off_no_grant", valid_cycles, vc);
    n = cyc;
    enable = 1'b1;
    expect_pkt(1, 64'h0000003344556677, n + 1, s, a);
    idle(GAP + 10);

    // Randomized traffic against the model.
    for (int i = 0; i < 12; i++) begin
      ready_pct = $urandom_range(30, 100);
      kind = $urandom_range(2);
      rk = {$urandom, $urandom};
      rm = {8'($urandom), 32'($urandom)};
      run_case(kind != 1, kind != 0, rk, rm, ~lg_m);
      idle(GAP + 10);
    end

    // Reset in the middle of a packet.
    ready_pct = 100;
    req(1, 0, 64'h0102030405060708, 40'h0);
    t = 0;
    while (cur_n < 3 && t < 100) begin step(); t++; end
    if (cur_n < 3) fail("rst_byte3_wait");
    rst = 1'b1;
    kbd_v = 1'b0;
    step();
    chk("rst_mid_valid", inj_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_counts", {kcnt, mcnt}, 32'd0);
    step();
    rst = 1'b0;
    mk = 0; mm = 0; lg_m = 1'b1;
    idle(5);
    chk("rst_no_ack", ack_q.size(), 0);
    chk("rst_no_pkt", pkt_q.size(), 0);
    run_case(1, 1, 64'h8899aabbccddeeff, 40'h2468ace013, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
